// File: rtl/queue_pkg.sv
// Shared occupancy-counter constants and the count-width helper.
package queue_pkg;
  localparam int DEF_MAX_COUNT   = 7;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction
endpackage

// File: rtl/sensor_edge_sync.sv
// Multi-flop synchronizer for an asynchronous sensor level plus rising-edge detection.
module sensor_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Decoded from registered history so the consumer can act on the same edge
  // that retires the event; the parent registers the visible strobe.
  assign pulse_o = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/queue_occupancy_counter.sv
// Saturating queue occupancy counter driven by synchronized arrival/departure sensors,
// with preset, sticky over/underflow flags and a peak-occupancy tracker.
module queue_occupancy_counter
  import queue_pkg::*;
#(
  parameter  int MAX_COUNT   = DEF_MAX_COUNT,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int CW          = cnt_width(MAX_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arr_i,
  input  logic          dep_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          clr_err_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          udf_o,
  output logic [CW-1:0] peak_o,
  output logic          arr_pulse_o,
  output logic          dep_pulse_o
);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  logic          w_arr, w_dep;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_ovf_set, w_udf_set;
  logic [CW-1:0] r_count, r_peak;
  logic          r_ovf, r_udf, r_arr_pulse, r_dep_pulse;

  sensor_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_arr_sync (
    .clk(clk), .rst(rst), .d_i(arr_i), .pulse_o(w_arr)
  );
  sensor_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dep_sync (
    .clk(clk), .rst(rst), .d_i(dep_i), .pulse_o(w_dep)
  );

  always_comb begin
    w_cnt_nxt = r_count;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    if (load_i) begin
      w_cnt_nxt = (load_val_i > MAX_C) ? MAX_C : load_val_i;
    end else if (w_arr && !w_dep) begin
      if (r_count == MAX_C) w_ovf_set = 1'b1;
      else                  w_cnt_nxt = r_count + CW'(1);
    end else if (w_dep && !w_arr) begin
      if (r_count == '0) w_udf_set = 1'b1;
      else               w_cnt_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_peak      <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_arr_pulse <= 1'b0;
      r_dep_pulse <= 1'b0;
    end else begin
      r_count     <= w_cnt_nxt;
      r_arr_pulse <= w_arr;
      r_dep_pulse <= w_dep;
      // A flag raised in the same cycle as a clear survives it.
      r_ovf       <= (r_ovf & ~clr_err_i) | w_ovf_set;
      r_udf       <= (r_udf & ~clr_err_i) | w_udf_set;
      if (clr_err_i || (w_cnt_nxt > r_peak)) r_peak <= w_cnt_nxt;
    end
  end

  assign count_o     = r_count;
  assign peak_o      = r_peak;
  assign ovf_o       = r_ovf;
  assign udf_o       = r_udf;
  assign full_o      = (r_count == MAX_C);
  assign empty_o     = (r_count == '0);
  assign arr_pulse_o = r_arr_pulse;
  assign dep_pulse_o = r_dep_pulse;
endmodule

// File: doc/queue_occupancy_counter.md
QUEUE_OCCUPANCY_COUNTER -- requirements
Module: queue_occupancy_counter

Interface
REQ-001 Parameter MAX_COUNT, default 7: highest legal occupancy (>=1).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per sensor input (>=2).
REQ-003 Derived width CW = $clog2(MAX_COUNT+1); all count-valued ports are CW bits wide.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 arr_i  in  1  raw arrival sensor level, asynchronous to clk.
REQ-007 dep_i  in  1  raw departure sensor level, asynchronous to clk.
REQ-008 load_i  in  1  synchronous preset strobe.
REQ-009 load_val_i  in  CW  preset occupancy value.
REQ-010 clr_err_i  in  1  clears sticky error flags and re-seeds peak.
REQ-011 count_o  out  CW  current occupancy.
REQ-012 full_o  out  1  high when count_o == MAX_COUNT.
REQ-013 empty_o  out  1  high when count_o == 0.
REQ-014 ovf_o  out  1  sticky overflow (arrival rejected at full).
REQ-015 udf_o  out  1  sticky underflow (departure rejected at empty).
REQ-016 peak_o  out  CW  maximum count_o since reset or last clr_err_i.
REQ-017 arr_pulse_o / dep_pulse_o  out  1 each  one-cycle qualified event strobes.

Function
REQ-018 Each sensor input SHALL pass through a SYNC_STAGES-flop synchronizer followed by a registered rising-edge detector; one pulse per low-to-high transition, however long the level is held.
REQ-019 An input first sampled high at edge k SHALL produce its event pulse, and the count update, at edge k+SYNC_STAGES; arr_pulse_o/dep_pulse_o are high during the cycle following that edge.
REQ-020 Arrival only, count < MAX_COUNT: count +1. Arrival only, count == MAX_COUNT: count holds, ovf_o set.
REQ-021 Departure only, count > 0: count -1. Departure only, count == 0: count holds, udf_o set.
REQ-022 Arrival and departure in the same cycle: count unchanged at every value including 0 and MAX_COUNT; no error flag set.
REQ-023 The counter SHALL never wrap; arithmetic is saturating within 0..MAX_COUNT.
REQ-024 load_i has priority over events: count = min(load_val_i, MAX_COUNT); events in that cycle are discarded and no error flags are set.
REQ-025 full_o, empty_o SHALL be registered-consistent with count_o (decoded from the count register, no extra latency).
REQ-026 peak_o updates on the same edge as count when new count > peak_o.
REQ-027 clr_err_i clears ovf_o and udf_o, and loads peak_o with the next count value; an error condition in the same cycle wins (flag ends set).
REQ-028 Idle inputs (no event, no load, no clear) SHALL leave all state unchanged.

Reset
REQ-029 rst asserted: count_o=0, peak_o=0, ovf_o=0, udf_o=0, full_o=0, empty_o=1, pulses=0, synchronizer and edge-detect flops=0, immediately and independent of clk.
REQ-030 Reset mid-operation SHALL discard in-flight synchronized events; a sensor held high through reset release SHALL generate one event after release (edge-detect history is 0).

Structure
REQ-031 Shared package queue_pkg holds the CW width function and default MAX_COUNT / SYNC_STAGES constants for reuse by display and teller blocks.
REQ-032 One sub-module, sensor_edge_sync (parameter SYNC_STAGES; ports clk, rst, d_i, pulse_o), instantiated twice.

Verification
REQ-033 MAX_COUNT=7, SYNC_STAGES=2: arr_i raised once, held 10 cycles -> exactly one arr_pulse_o; count_o 0->1 on 2nd edge after first high sample.
REQ-034 Eight separate arrivals from 0 -> count_o saturates at 7, full_o=1, ovf_o=1 after 8th; peak_o=7.
REQ-035 At count 0, one departure -> count_o stays 0, udf_o=1; clr_err_i pulse -> udf_o=0.
REQ-036 At count 7 and at count 0, arr_i and dep_i rising together -> count unchanged, ovf_o=udf_o=0.
REQ-037 load_i with load_val_i=5 coincident with arrival pulse -> count_o=5; MAX_COUNT=5 with load_val_i=7 -> count_o=5, full_o=1.
REQ-038 rst asserted asynchronously mid-count (count 4, arrival in synchronizer) -> all outputs at reset values at once, no increment after release.
